fetch_sequencer: RTL and testbench
==================================

# fetch_sequencer

Instruction-fetch controller that owns the architectural fetch PC and drives the instruction-memory request port. It replaces the free-running PC register when the core moves to a memory with variable latency:
- issues sequential fetches with at most 2 requests in flight;
- buffers returned instructions in a 2-entry in-order queue toward decode;
- squashes stale responses on a branch/jump redirect;
- traps misaligned redirect targets.

## Interface
Parameters:
- RESET_PC, 32'h0, fetch address loaded on reset.

Ports:
- CLK  in  1  core clock, all state updates on rising edge.
- Reset  in  1  synchronous, active-high; sampled on CLK rising edge.
- IMemReq  out  1  fetch request valid.
- IMemAddr  out  32  fetch address; equals internal FetchPC.
- IMemReady  in  1  memory accepts request this cycle (handshake = IMemReq && IMemReady).
- IMemValid  in  1  response valid; responses return in request order, no earlier than the cycle after acceptance.
- IMemRData  in  32  response instruction word.
- Redirect  in  1  taken branch/jump from execute.
- RedirectPC  in  32  new fetch target (PCTarget or ALUResult path).
- InstrValid  out  1  queue head valid toward decode.
- InstrReady  in  1  decode accepts head (pop = InstrValid && InstrReady).
- Instr  out  32  head instruction word.
- InstrPC  out  32  address of head instruction.
- InstrPCPlus4  out  32  InstrPC + 4, modulo 2^32.
- Fault  out  1  misaligned redirect trap, sticky until Reset.

## Operation
State:
- FetchPC (32 b).
- Outstanding count O (0..2).
- Drop count D (0..2), counting responses still owed for squashed requests.
- Queue of 2 entries {Instr, PC}, occupancy C (0..2).
- FSM state ∈ {RUN, FAULT}.

Issue rule (RUN only):
- IMemReq = !Redirect && (O + C < 2 || (O + C == 2 && pop)).
- The pop term is a combinational path from InstrReady; this is intentional and gives 1 instr/cycle on 1-cycle memory.
- On handshake: FetchPC <= FetchPC + 4 (wraps 32'hFFFFFFFC -> 0), O increments.

Response:
- IMemValid decrements O.
- If D > 0: word is discarded and D decrements.
- Otherwise: {IMemRData, PC} is pushed; PC is tracked by a per-request address FIFO of depth 2.

Queue:
- FIFO order.
- Push and pop in the same cycle are both allowed, including at C == 2, because the issue rule guarantees no overflow.
- Push into a full queue without a pop is impossible by construction; assert it in simulation.

Redirect (RUN, RedirectPC[1:0] == 2'b00):
- Same cycle: IMemReq forced 0, and any pop that cycle still completes.
- Next edge:
  - FetchPC <= RedirectPC.
  - Queue flushed (C = 0).
  - D <= O minus any response accepted that cycle; that response is itself discarded.
- Issue resumes the following cycle at RedirectPC.

Misaligned redirect (RedirectPC[1:0] != 0):
- Next state FAULT: Fault = 1, queue flushed, IMemReq = 0, InstrValid = 0.
- In-flight responses are still counted and dropped.
- FAULT is left only by Reset.

Reset:
- Drives IMemReq = 0, IMemAddr = RESET_PC, InstrValid = 0, Instr = 0, InstrPC = 0, InstrPCPlus4 = 4, Fault = 0.
- Clears O, C and D; state = RUN.
- The instruction memory shares the same Reset, so no responses survive a reset.

## Timing
- First IMemReq in the first cycle Reset is low, with IMemAddr = RESET_PC.
- Response-to-InstrValid latency: 1 cycle, since the queue is registered and there is no bypass.
- 1-cycle memory with InstrReady = 1: steady state delivers one instruction per cycle after a 2-cycle startup.
- InstrValid, Instr and InstrPC are registered outputs. IMemReq is combinational from state, Redirect and the pop term.
- Redirect to first fetch at the new target: 1 cycle. Redirect to InstrValid of the target instruction: memory latency + 2 cycles.
- Redirect together with IMemValid: the response is dropped. Redirect while in FAULT: ignored.

## Test plan
1. Reset, then 1-cycle memory returning the address as data, InstrReady = 1 -> IMemAddr 0,4,8,… each cycle; InstrPC 0,4,8 on consecutive cycles from cycle 3; Instr == InstrPC.
2. InstrReady = 0 from start -> exactly 2 handshakes (0, 4); IMemReq stays 0 afterwards; raise InstrReady -> Instr 0 then 4, then fetch resumes at 8.
3. 3-cycle memory with 2 requests in flight (0, 4), Redirect with RedirectPC = 0x100 -> both responses dropped; next InstrValid shows InstrPC = 0x100, InstrPCPlus4 = 0x104.
4. Redirect with RedirectPC = 0x102 -> Fault = 1 next cycle; IMemReq = 0 and InstrValid = 0 for 20 cycles; Reset -> Fault = 0 and fetch restarts at RESET_PC.
5. RESET_PC = 32'hFFFFFFF8 -> IMemAddr FFFFFFF8, FFFFFFFC, 00000000; InstrPCPlus4 for FFFFFFFC is 0.
6. Reset asserted mid-stream with C = 2 and O = 1 -> next cycle InstrValid = 0, IMemAddr = RESET_PC; the first delivered Instr corresponds to RESET_PC.

Source files
------------

// File: rtl/fetch_sequencer.sv
// Instruction-fetch controller: owns the fetch PC, keeps at most two requests in
// flight to a variable-latency instruction memory and buffers responses for decode.
module fetch_sequencer #(
    parameter logic [31:0] RESET_PC = 32'h0
) (
    input  logic        CLK,
    input  logic        Reset,
    output logic        IMemReq,
    output logic [31:0] IMemAddr,
    input  logic        IMemReady,
    input  logic        IMemValid,
    input  logic [31:0] IMemRData,
    input  logic        Redirect,
    input  logic [31:0] RedirectPC,
    output logic        InstrValid,
    input  logic        InstrReady,
    output logic [31:0] Instr,
    output logic [31:0] InstrPC,
    output logic [31:0] InstrPCPlus4,
    output logic        Fault
);
    typedef enum logic {RUN, FAULT} state_t;

    state_t           state;
    logic [31:0]      fetch_pc;
    logic [1:0]       out_cnt, drop_cnt;
    logic [1:0]       q_vld, q_vld_n;
    logic [1:0][31:0] q_instr, q_pc, a_pc;
    logic [1:0][31:0] q_instr_n, q_pc_n, a_pc_n;
    logic [2:0]       occ;
    logic             pop, hs, push, a_idx;

    assign pop   = q_vld[0] && InstrReady;
    assign occ   = 3'(out_cnt) + 3'(q_vld[0]) + 3'(q_vld[1]);
    // Counting in-flight requests against queue space guarantees every response has a slot.
    assign IMemReq = !Reset && (state == RUN) && !Redirect &&
                     ((occ < 3'd2) || ((occ == 3'd2) && pop));
    assign hs    = IMemReq && IMemReady;
    assign push  = IMemValid && (drop_cnt == 2'd0) && (state == RUN) && !Redirect;
    assign a_idx = out_cnt[0] && !IMemValid;

    assign IMemAddr     = fetch_pc;
    assign InstrValid   = q_vld[0];
    assign Instr        = q_instr[0];
    assign InstrPC      = q_pc[0];
    assign InstrPCPlus4 = q_pc[0] + 32'd4;
    assign Fault        = (state == FAULT);

    always_comb begin
        q_vld_n   = q_vld;
        q_instr_n = q_instr;
        q_pc_n    = q_pc;
        if (pop) begin
            q_vld_n      = {1'b0, q_vld[1]};
            q_instr_n[0] = q_instr[1];
            q_pc_n[0]    = q_pc[1];
        end
        if (push) begin
            if (q_vld_n[0]) begin
                q_vld_n[1]   = 1'b1;
                q_instr_n[1] = IMemRData;
                q_pc_n[1]    = a_pc[0];
            end else begin
                q_vld_n[0]   = 1'b1;
                q_instr_n[0] = IMemRData;
                q_pc_n[0]    = a_pc[0];
            end
        end
    end

    // Per-request address FIFO; head always belongs to the next returning response.
    always_comb begin
        a_pc_n = a_pc;
        if (IMemValid)
            a_pc_n[0] = a_pc[1];
        if (hs)
            a_pc_n[a_idx] = fetch_pc;
    end

    always_ff @(posedge CLK) begin
        if (Reset) begin
            state    <= RUN;
            fetch_pc <= RESET_PC;
            out_cnt  <= 2'd0;
            drop_cnt <= 2'd0;
            q_vld    <= 2'b00;
            q_instr  <= '0;
            q_pc     <= '0;
            a_pc     <= '0;
        end else begin
            out_cnt <= out_cnt + 2'(hs) - 2'(IMemValid);
            a_pc    <= a_pc_n;
            q_instr <= q_instr_n;
            q_pc    <= q_pc_n;
            case (state)
                RUN: begin
                    if (Redirect) begin
                        q_vld    <= 2'b00;
                        drop_cnt <= out_cnt - 2'(IMemValid);
                        if (RedirectPC[1:0] != 2'b00)
                            state <= FAULT;
                        else
                            fetch_pc <= RedirectPC;
                    end else begin
                        q_vld <= q_vld_n;
                        if (IMemValid && (drop_cnt != 2'd0))
                            drop_cnt <= drop_cnt - 2'd1;
                        if (hs)
                            fetch_pc <= fetch_pc + 32'd4;
                    end
                end
                FAULT: begin
                    if (IMemValid && (drop_cnt != 2'd0))
                        drop_cnt <= drop_cnt - 2'd1;
                end
                default: state <= RUN;
            endcase
        end
    end

    always @(posedge CLK)
        if (!Reset)
            assert (!(push && q_vld[1] && !pop));

endmodule

// File: tb/tb_fetch_sequencer.sv
// Randomized scoreboard bench for fetch_sequencer: a memory model plus a stream model
// of the expected instruction sequence (consecutive words from the last reset/redirect).
module tb_fetch_sequencer;
    localparam logic [31:0] RPC = 32'hFFFF_FFF0;

    logic        CLK, Reset, IMemReq, IMemReady, IMemValid, Redirect;
    logic        InstrValid, InstrReady, Fault;
    logic [31:0] IMemAddr, IMemRData, RedirectPC, Instr, InstrPC, InstrPCPlus4;

    fetch_sequencer #(.RESET_PC(RPC)) dut (
        .CLK(CLK), .Reset(Reset), .IMemReq(IMemReq), .IMemAddr(IMemAddr),
        .IMemReady(IMemReady), .IMemValid(IMemValid), .IMemRData(IMemRData),
        .Redirect(Redirect), .RedirectPC(RedirectPC), .InstrValid(InstrValid),
        .InstrReady(InstrReady), .Instr(Instr), .InstrPC(InstrPC),
        .InstrPCPlus4(InstrPCPlus4), .Fault(Fault)
    );

    typedef struct { logic [31:0] addr; int due; } mreq_t;

    int          checks = 0, failures = 0;
    int          cyc = 0, hs_cnt = 0, pop_cnt = 0, idle = 0;
    int          lat_lo = 1, lat_hi = 1, mrdy_pct = 100;
    mreq_t       mem_q[$];
    logic [31:0] exp_q[$];
    logic [31:0] next_pc, fa_exp, prev_rpc;
    bit          exp_fault = 0, just_reset = 0, prev_rst = 0, prev_redir = 0;

    initial begin
        CLK = 0;
        forever #5 CLK = ~CLK;
    end

    always @(posedge CLK) cyc++;

    function automatic logic [31:0] memf(input logic [31:0] a);
        return {a[15:0], a[31:16]} ^ 32'h9E37_79B9;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic chkb(input string name, input logic act, input logic exp);
        chk(name, {31'd0, act}, {31'd0, exp});
    endtask

    // One cycle of stimulus; bookkeeping for the previous cycle's reset/redirect first.
    task automatic step(input bit rst, input bit redir, input logic [31:0] rpc, input bit irdy);
        @(posedge CLK); #1;
        if (prev_rst) begin
            exp_q.delete();
            mem_q.delete();
            next_pc = RPC; fa_exp = RPC;
            exp_fault = 0; just_reset = 1; idle = 0;
        end else if (prev_redir && !exp_fault) begin
            exp_q.delete();
            idle = 0;
            if (prev_rpc[1:0] != 2'b00) exp_fault = 1;
            else begin next_pc = prev_rpc; fa_exp = prev_rpc; end
        end
        while (!exp_fault && exp_q.size() < 8) begin
            exp_q.push_back(next_pc);
            next_pc = next_pc + 32'd4;
        end
        Reset      = rst;
        Redirect   = redir && !rst;
        RedirectPC = rpc;
        InstrReady = irdy && !rst;
        IMemReady  = ($urandom_range(99) < mrdy_pct);
        IMemValid  = 1'b0;
        IMemRData  = '0;
        if (!rst && mem_q.size() > 0 && mem_q[0].due <= cyc) begin
            IMemValid = 1'b1;
            IMemRData = memf(mem_q[0].addr);
            void'(mem_q.pop_front());
        end
        prev_rst   = rst;
        prev_redir = redir && !rst;
        prev_rpc   = rpc;
    endtask

    // Monitor: samples mid-cycle, records accepted fetches, scores deliveries.
    always @(negedge CLK) begin
        if (!Reset) begin
            if (just_reset) begin
                chkb("rst_valid", InstrValid, 1'b0);
                chk("rst_addr", IMemAddr, RPC);
                chk("rst_instr", Instr, 32'd0);
                chk("rst_pc", InstrPC, 32'd0);
                chk("rst_pc4", InstrPCPlus4, 32'd4);
                just_reset = 0;
            end
            chkb("fault", Fault, exp_fault);
            if (exp_fault) begin
                chkb("fault_req", IMemReq, 1'b0);
                chkb("fault_valid", InstrValid, 1'b0);
            end
            if (Redirect) chkb("redir_req", IMemReq, 1'b0);
            if (IMemReq && IMemReady) begin
                mreq_t m;
                chk("fetch_addr", IMemAddr, fa_exp);
                chkb("inflight", (mem_q.size() + int'(IMemValid)) < 2, 1'b1);
                fa_exp = fa_exp + 32'd4;
                m.addr = IMemAddr;
                m.due  = cyc + $urandom_range(lat_hi, lat_lo);
                mem_q.push_back(m);
                hs_cnt++;
            end
            if (InstrValid && InstrReady) begin
                pop_cnt++;
                idle = 0;
                if (exp_q.size() == 0) begin
                    chkb("unexpected_instr", 1'b1, 1'b0);
                end else begin
                    logic [31:0] pc;
                    pc = exp_q.pop_front();
                    chk("instr_pc", InstrPC, pc);
                    chk("instr", Instr, memf(pc));
                    chk("instr_pc4", InstrPCPlus4, pc + 32'd4);
                end
            end else if (!exp_fault && InstrReady) begin
                idle++;
                chkb("progress", idle <= 40, 1'b1);
                if (idle > 40) idle = 0;
            end
        end
    end

    initial begin
        int h0, p0;
        Reset = 1; Redirect = 0; RedirectPC = '0; InstrReady = 0;
        IMemReady = 0; IMemValid = 0; IMemRData = '0;
        next_pc = RPC; fa_exp = RPC; prev_rpc = '0;

        // Full rate on 1-cycle memory, crossing the address wrap.
        step(1, 0, '0, 0); step(1, 0, '0, 0);
        h0 = hs_cnt; p0 = pop_cnt;
        repeat (10) step(0, 0, '0, 1);
        @(negedge CLK); #1;
        chk("t1_fetches", hs_cnt - h0, 10);
        chk("t1_delivered", pop_cnt - p0, 8);

        // Decode stalled: exactly two fetches, then drain and resume.
        step(1, 0, '0, 0);
        h0 = hs_cnt;
        repeat (8) step(0, 0, '0, 0);
        @(negedge CLK); #1;
        chk("t2_fetches", hs_cnt - h0, 2);
        chkb("t2_req_idle", IMemReq, 1'b0);
        repeat (10) step(0, 0, '0, 1);

        // Redirect with two slow requests in flight.
        lat_lo = 3; lat_hi = 3;
        step(1, 0, '0, 1);
        step(0, 0, '0, 1); step(0, 0, '0, 1);
        step(0, 1, 32'h100, 1);
        p0 = pop_cnt;
        repeat (14) step(0, 0, '0, 1);
        @(negedge CLK); #1;
        chkb("t3_delivered", (pop_cnt - p0) >= 1, 1'b1);

        // Misaligned redirect traps until reset.
        lat_lo = 1; lat_hi = 3; mrdy_pct = 75;
        repeat (3) step(0, 0, '0, 1);
        step(0, 1, 32'h102, 1);
        repeat (20) step(0, ($urandom_range(3) == 0), 32'h200, 1);
        step(1, 0, '0, 1);
        repeat (6) step(0, 0, '0, 1);

        // Randomized mix.
        for (int i = 0; i < 3000; i++) begin
            bit r, d;
            logic [31:0] t;
            r = ($urandom_range(199) == 0) || (exp_fault && $urandom_range(9) == 0);
            d = !r && ($urandom_range(19) == 0);
            t = $urandom();
            if ($urandom_range(7) != 0) t[1:0] = 2'b00;
            if ($urandom_range(3) == 0) t[31:5] = '1;
            step(r, d, t, $urandom_range(3) != 0);
        end
        @(negedge CLK); #1;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
